// File: rtl/boa_mem_arbiter.sv
// boa_mem_arbiter: fetch/data two-port arbiter onto one shared memory bus, with a wait-state timeout abort.
// Optional macro BOA_ARB_ROUND_ROBIN_EN: round-robin tie-break instead of fixed data-port priority.
module boa_mem_arbiter #(
   parameter int unsigned TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        i_re,
   input  logic [31:2] i_addr,
   output logic        i_ready,
   output logic [31:0] i_rdata,
   input  logic        d_re,
   input  logic [3:0]  d_we,
   input  logic [31:2] d_addr,
   input  logic [31:0] d_wdata,
   output logic        d_ready,
   output logic [31:0] d_rdata,
   output logic        m_re,
   output logic [3:0]  m_we,
   output logic [31:2] m_addr,
   output logic [31:0] m_wdata,
   input  logic        m_ready,
   input  logic [31:0] m_rdata,
   output logic        err
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      BUSY_I = 2'd1,
      BUSY_D = 2'd2
   } state_t;

   localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

   state_t     state_r;
   state_t     state_nxt_s;
   logic [7:0] wait_cnt_r;
   logic [7:0] wait_cnt_nxt_s;
   logic       d_req_s;
   logic       grant_i_s;
   logic       grant_d_s;
   logic       busy_s;
   logic       timeout_s;
   logic       done_s;

`ifdef BOA_ARB_ROUND_ROBIN_EN
   logic       last_d_r;      // 1 when the data port completed most recently
   logic       last_d_nxt_s;
`endif

   assign d_req_s   = d_re | (d_we != 4'h0);
   assign busy_s    = ~rst & (state_r != IDLE);
   assign timeout_s = busy_s & ~m_ready & (wait_cnt_r == TIMEOUT_CNT);
   assign done_s    = (grant_i_s | grant_d_s) & (m_ready | timeout_s);

   // Grant selection: held while busy, arbitrated in IDLE, suppressed in reset
   always_comb begin
      grant_i_s = 1'b0;
      grant_d_s = 1'b0;
      if (rst) begin
         grant_i_s = 1'b0;
         grant_d_s = 1'b0;
      end else begin
         case (state_r)
            IDLE: begin
               if (i_re && d_req_s) begin
`ifdef BOA_ARB_ROUND_ROBIN_EN
                  grant_i_s = last_d_r;
                  grant_d_s = ~last_d_r;
`else
                  grant_d_s = 1'b1;
`endif
               end else begin
                  grant_i_s = i_re;
                  grant_d_s = d_req_s;
               end
            end
            BUSY_I:  grant_i_s = 1'b1;
            BUSY_D:  grant_d_s = 1'b1;
            default: begin
               grant_i_s = 1'b0;
               grant_d_s = 1'b0;
            end
         endcase
      end
   end

   // Forward the granted port onto the memory bus; bus is all-zero without a grant
   always_comb begin
      m_re    = 1'b0;
      m_we    = 4'h0;
      m_addr  = 30'h0;
      m_wdata = 32'h0;
      if (grant_i_s) begin
         m_re   = i_re;
         m_addr = i_addr;
      end else if (grant_d_s) begin
         m_re    = d_re;
         m_we    = d_we;
         m_addr  = d_addr;
         m_wdata = d_wdata;
      end else begin
         m_re    = 1'b0;
         m_we    = 4'h0;
      end
   end

   assign i_ready = grant_i_s & done_s;
   assign d_ready = grant_d_s & done_s;
   assign i_rdata = (grant_i_s & timeout_s) ? 32'h0 : m_rdata;
   assign d_rdata = (grant_d_s & timeout_s) ? 32'h0 : m_rdata;
   assign err     = timeout_s;

   // Next state and wait counter
   always_comb begin
      state_nxt_s    = state_r;
      wait_cnt_nxt_s = wait_cnt_r;
      case (state_r)
         IDLE: begin
            wait_cnt_nxt_s = 8'h0;
            if (grant_i_s && !m_ready) begin
               state_nxt_s = BUSY_I;
            end else if (grant_d_s && !m_ready) begin
               state_nxt_s = BUSY_D;
            end else begin
               state_nxt_s = IDLE;
            end
         end
         BUSY_I, BUSY_D: begin
            if (done_s) begin
               state_nxt_s    = IDLE;
               wait_cnt_nxt_s = 8'h0;
            end else begin
               wait_cnt_nxt_s = wait_cnt_r + 8'd1;
            end
         end
         default: begin
            state_nxt_s    = IDLE;
            wait_cnt_nxt_s = 8'h0;
         end
      endcase
   end

   // State and counter registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r    <= IDLE;
         wait_cnt_r <= 8'h0;
      end else begin
         state_r    <= state_nxt_s;
         wait_cnt_r <= wait_cnt_nxt_s;
      end
   end

`ifdef BOA_ARB_ROUND_ROBIN_EN
   // Remember which port finished last, normal or aborted
   always_comb begin
      if (done_s) begin
         last_d_nxt_s = grant_d_s;
      end else begin
         last_d_nxt_s = last_d_r;
      end
   end

   // Last-grant register, data after reset so fetch wins the first tie
   always_ff @(posedge clk) begin
      if (rst) begin
         last_d_r <= 1'b1;
      end else begin
         last_d_r <= last_d_nxt_s;
      end
   end
`endif

endmodule

// File: doc/boa_mem_arbiter.md
BOA_MEM_ARBITER -- requirements
Module: boa_mem_arbiter

Interface
REQ-001 Parameter: TIMEOUT, default 255, number of consecutive wait-state cycles after which a transaction is aborted (range 1..255).
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 i_re  input  1  fetch port read request.
REQ-005 i_addr  input  30  fetch port word address [31:2].
REQ-006 i_ready  output  1  fetch port transaction complete.
REQ-007 i_rdata  output  32  fetch port read data.
REQ-008 d_re  input  1  data port read request.
REQ-009 d_we  input  4  data port byte write enables.
REQ-010 d_addr  input  30  data port word address [31:2].
REQ-011 d_wdata  input  32  data port write data.
REQ-012 d_ready  output  1  data port transaction complete.
REQ-013 d_rdata  output  32  data port read data.
REQ-014 m_re, m_we[3:0], m_addr[31:2], m_wdata[31:0]  output  shared memory bus request.
REQ-015 m_ready  input  1  memory completes the current transaction this cycle.
REQ-016 m_rdata  input  32  memory read data, valid when m_ready=1.
REQ-017 err  output  1  one-cycle pulse on timeout abort.

Function
REQ-018 A port is requesting when re=1 or we!=0; the requester SHALL hold its request signals stable until its ready is 1.
REQ-019 FSM states SHALL be IDLE, BUSY_I, BUSY_D.
REQ-020 In IDLE with one requester, that port SHALL be granted in the same cycle (zero added latency) and its request forwarded combinationally to m_*.
REQ-021 In IDLE with both requesting, the winner SHALL be chosen per REQ-031/REQ-032.
REQ-022 Granted port in IDLE with m_ready=1: its ready SHALL be 1 and FSM SHALL stay IDLE; with m_ready=0: FSM SHALL move to BUSY_I/BUSY_D.
REQ-023 In BUSY_x, the grant SHALL be held regardless of other requests; m_* SHALL forward port x; on m_ready=1 port x ready SHALL be 1 and FSM SHALL return to IDLE.
REQ-024 Non-granted port ready SHALL be 0; both i_rdata and d_rdata SHALL equal m_rdata (qualified by ready).
REQ-025 No grant: m_re=0, m_we=0, m_addr and m_wdata SHALL be 0.
REQ-026 Wait counter (8 bit) SHALL clear on entering BUSY_x and increment each BUSY cycle with m_ready=0.
REQ-027 When the counter equals TIMEOUT with m_ready=0: granted ready SHALL be 1, its rdata SHALL be forced to 0, err SHALL be 1 for that cycle, FSM SHALL return to IDLE.
REQ-028 m_ready=1 in the same cycle as the timeout condition SHALL win: normal completion, err=0.
REQ-029 A grant SHALL never switch mid-transaction; back-to-back transactions SHALL be possible with no idle cycle.
REQ-030 Last-grant register SHALL record the port that completed most recently (normal or abort).

Reset
REQ-031 While rst=1: FSM=IDLE, counter=0, err=0, last-grant=data, i_ready=d_ready=0, m_re=0, m_we=0; rst asserted mid-transaction SHALL drop the transaction with no completion signalled.

Configuration
REQ-032 Macro BOA_ARB_ROUND_ROBIN_EN defined: on a tie, the port not in last-grant SHALL win (fetch first after reset); undefined: data port SHALL always win ties (fixed priority) and last-grant is unused.

Verification
REQ-033 Fetch only, i_addr=30'h100, m_ready=1 always -> i_ready=1 same cycle, m_addr=30'h100, i_rdata=m_rdata.
REQ-034 Data write d_we=4'hF, d_addr=30'h40, d_wdata=32'hdead_beef, m_ready low 3 cycles -> m_we=4'hF held 4 cycles, d_ready=1 on cycle 4 only, i_ready=0 throughout.
REQ-035 Both request continuously, m_ready=1, RR enabled -> grants alternate I,D,I,D starting with I after reset; RR disabled -> D granted every cycle, i_ready stays 0.
REQ-036 TIMEOUT=4, fetch with m_ready=0 forever -> i_ready=1, i_rdata=0, err=1 on abort cycle, FSM IDLE next cycle.
REQ-037 rst=1 in BUSY_D cycle 2 -> next cycle m_re=0, m_we=0, d_ready=0, fetch then granted first.
